// File: rtl/tlc_pkg.sv
// Shared types and helpers for the multi-way traffic-light controller.
// Phase encoding, fast-mode green length, round-robin search, range checks.
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GRN    = 2'd1,
    ST_YLW    = 2'd2
  } phase_e;

  localparam int MAX_WAY = 8;

  // Fast-mode green: shortened, but never below one tick.
  function automatic int fm_green(
    input int t_grn,
    input int shift
  );
    int g;
    g = t_grn >> shift;
    return (g < 1) ? 1 : g;
  endfunction

  // First pending way after act in circular order; act if none.
  function automatic logic [2:0] next_pending(
    input logic [7:0] pend,
    input logic [2:0] act,
    input int         n_way
  );
    logic [2:0] r;
    logic       found;
    int         idx;
    r     = act;
    found = 1'b0;
    for (int k = 1; k < MAX_WAY; k++) begin
      idx = int'(act) + k;
      if (idx >= n_way) idx = idx - n_way;
      if (!found && k < n_way && pend[idx[2:0]]) begin
        r     = idx[2:0];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Parameter range check used at elaboration.
  function automatic bit cfg_ok(
    input int n_way,
    input int cnt_w,
    input int pre_div,
    input int t_grn,
    input int t_ylw,
    input int t_allred
  );
    int lim;
    if (cnt_w < 1 || cnt_w > 30) return 1'b0;
    lim = 1 << cnt_w;
    return n_way >= 2 && n_way <= MAX_WAY &&
           pre_div >= 1 && pre_div <= lim &&
           t_grn >= 1 && t_grn <= lim - 1 &&
           t_ylw >= 1 && t_ylw <= lim &&
           t_allred >= 1 && t_allred <= lim;
  endfunction

endpackage

// File: rtl/tlc_prescaler.sv
// Time-base prescaler: one registered TICK every PRE_DIV cycles.
// TEST forces a tick every cycle; any TEST edge restarts the count.
module tlc_prescaler #(
  parameter int PRE_DIV = 16,
  parameter int CNT_W   = 8
) (
  input  logic CK,
  input  logic CLR_N,
  input  logic TEST,
  output logic TICK
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(PRE_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             test_q;

  // Next count and tick; tick is flagged for the cycle at terminal count.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == TC) cnt_d = '0;
    if (TEST || (TEST != test_q)) cnt_d = '0;
    tick_d = TEST || (cnt_d == TC);
  end

  // Prescaler state registers.
  always_ff @(posedge CK or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      test_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      test_q <= TEST;
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/tlc_multiway_ctrl.sv
// Multi-way traffic-light controller: round-robin demand service,
// programmable phase lengths, registered lamp outputs.
module tlc_multiway_ctrl
  import tlc_pkg::*;
#(
  parameter int N_WAY    = 2,
  parameter int CNT_W    = 8,
  parameter int PRE_DIV  = 16,
  parameter int T_GRN    = 40,
  parameter int T_YLW    = 4,
  parameter int T_ALLRED = 2,
  parameter int FM_SHIFT = 2,
  localparam int AW      = $clog2(N_WAY)
) (
  input  logic             CK,
  input  logic             CLR_N,
  input  logic             FM,
  input  logic             TEST,
  input  logic [N_WAY-1:0] REQ,
  output logic [N_WAY-1:0] GRN,
  output logic [N_WAY-1:0] YLW,
  output logic [N_WAY-1:0] RED,
  output logic [AW-1:0]    ACT,
  output logic             TICK
);

  if (!cfg_ok(N_WAY, CNT_W, PRE_DIV,
              T_GRN, T_YLW, T_ALLRED)) begin : g_cfg_err
    $error("tlc_multiway_ctrl: parameter out of range");
  end

  localparam logic [CNT_W-1:0] LD_GRN = CNT_W'(T_GRN - 1);
  localparam logic [CNT_W-1:0] LD_FM  =
    CNT_W'(fm_green(T_GRN, FM_SHIFT) - 1);
  localparam logic [CNT_W-1:0] LD_YLW = CNT_W'(T_YLW - 1);
  localparam logic [CNT_W-1:0] LD_AR  = CNT_W'(T_ALLRED - 1);

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [AW-1:0]    act_q, act_d;
  logic [N_WAY-1:0] pend_q, pend_d;
  logic             first_q, first_d;
  logic [N_WAY-1:0] grn_q, grn_d;
  logic [N_WAY-1:0] ylw_q, ylw_d;
  logic [N_WAY-1:0] red_q, red_d;

  logic             tick;
  logic [N_WAY-1:0] act_mask;
  logic [N_WAY-1:0] grn_mask;
  logic [AW-1:0]    nxt;
  logic             other;

  tlc_prescaler #(
    .PRE_DIV (PRE_DIV),
    .CNT_W   (CNT_W)
  ) u_pre (
    .CK    (CK),
    .CLR_N (CLR_N),
    .TEST  (TEST),
    .TICK  (tick)
  );

  assign act_mask = N_WAY'(1) << act_q;
  assign grn_mask = (state_q == ST_GRN) ? act_mask : '0;
  assign other    = |(pend_q & ~act_mask);
  assign nxt      = first_q ? '0 :
    AW'(next_pending(8'(pend_q), 3'(act_q), N_WAY));

  // Phase sequencing, timer, pending bits and next lamp pattern.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    act_d   = act_q;
    first_d = first_q;
    pend_d  = pend_q | (REQ & ~grn_mask);
    if (tick) begin
      unique case (state_q)
        ST_ALLRED: begin
          if (timer_q == '0) begin
            state_d = ST_GRN;
            act_d   = nxt;
            first_d = 1'b0;
            timer_d = FM ? LD_FM : LD_GRN;
            pend_d  = pend_d & ~(N_WAY'(1) << nxt);
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        ST_GRN: begin
          if (timer_q != '0) begin
            timer_d = timer_q - CNT_W'(1);
          end else if (other) begin
            state_d = ST_YLW;
            timer_d = LD_YLW;
          end
        end
        ST_YLW: begin
          if (timer_q == '0) begin
            state_d = ST_ALLRED;
            timer_d = LD_AR;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_ALLRED;
          timer_d = LD_AR;
        end
      endcase
    end
    grn_d = '0;
    ylw_d = '0;
    if (state_d == ST_GRN) grn_d = N_WAY'(1) << act_d;
    if (state_d == ST_YLW) ylw_d = N_WAY'(1) << act_d;
    red_d = ~(grn_d | ylw_d);
  end

  // Controller state and registered lamp drivers.
  always_ff @(posedge CK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_ALLRED;
      timer_q <= LD_AR;
      act_q   <= '0;
      pend_q  <= '0;
      first_q <= 1'b1;
      grn_q   <= '0;
      ylw_q   <= '0;
      red_q   <= '1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      first_q <= first_d;
      grn_q   <= grn_d;
      ylw_q   <= ylw_d;
      red_q   <= red_d;
    end
  end

  assign GRN  = grn_q;
  assign YLW  = ylw_q;
  assign RED  = red_q;
  assign ACT  = act_q;
  assign TICK = tick;

endmodule

// File: tb/tb_tlc_multiway_ctrl.sv
// Bench for tlc_multiway_ctrl: expected lamp segments are queued by the
// stimulus and checked by an independent monitor as the lamps change.
module tb_tlc_multiway_ctrl;

  logic       CK    = 1'b0;
  logic       CLR_N = 1'b0;
  logic       FM    = 1'b0;
  logic       TEST  = 1'b0;
  logic [2:0] REQ   = 3'b000;
  logic [2:0] GRN, YLW, RED;
  logic [1:0] ACT;
  logic       TICK;

  tlc_multiway_ctrl #(
    .N_WAY    (3),
    .CNT_W    (8),
    .PRE_DIV  (4),
    .T_GRN    (5),
    .T_YLW    (2),
    .T_ALLRED (1),
    .FM_SHIFT (2)
  ) dut (
    .CK    (CK),
    .CLR_N (CLR_N),
    .FM    (FM),
    .TEST  (TEST),
    .REQ   (REQ),
    .GRN   (GRN),
    .YLW   (YLW),
    .RED   (RED),
    .ACT   (ACT),
    .TICK  (TICK)
  );

  always #5 CK = ~CK;

  typedef struct packed {
    logic [2:0]  g;
    logic [2:0]  y;
    logic [2:0]  r;
    logic [1:0]  a;
    logic [15:0] len;
  } seg_t;

  seg_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic seg_t seg(
    input logic [2:0] g,
    input logic [2:0] y,
    input logic [2:0] r,
    input logic [1:0] a,
    input int         len
  );
    seg_t s;
    s.g   = g;
    s.y   = y;
    s.r   = r;
    s.a   = a;
    s.len = 16'(len);
    return s;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
  endtask

  task automatic rst_rel();
    @(posedge CK);
    #2 CLR_N = 1'b1;
  endtask

  // Monitor: closes a segment on each lamp/ACT change and checks it.
  initial begin : mon
    logic [10:0] prev;
    logic [10:0] cur;
    int          len;
    bit          in_rst;
    seg_t        e;
    prev   = '0;
    len    = 0;
    in_rst = 1'b1;
    forever begin
      @(negedge CK);
      cur = {GRN, YLW, RED, ACT};
      if (!CLR_N) begin
        if (!in_rst) begin
          n_chk++;
          if (exp_q.size() == 0) n_pass++;
          else begin
            $display("FAIL seg_drain: %0d segments left, required 0",
                     exp_q.size());
            exp_q.delete();
          end
        end
        in_rst = 1'b1;
        prev   = cur;
        len    = 0;
      end else if (cur == prev) begin
        in_rst = 1'b0;
        len++;
      end else begin
        in_rst = 1'b0;
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL seg_extra: got g=%b y=%b r=%b act=%0d len=%0d, required none",
                   prev[10:8], prev[7:5], prev[4:2], prev[1:0], len);
        end else begin
          e = exp_q.pop_front();
          if (e == {prev, 16'(len)}) n_pass++;
          else
            $display("FAIL seg: got g=%b y=%b r=%b act=%0d len=%0d, required g=%b y=%b r=%b act=%0d len=%0d",
                     prev[10:8], prev[7:5], prev[4:2], prev[1:0], len,
                     e.g, e.y, e.r, e.a, e.len);
        end
        prev = cur;
        len  = 1;
      end
    end
  end

  int bad_g;
  int bad_y;
  int n_tick;

  initial begin : stim
    // 1: reset state, then first green is way 0 after 4 all-red cycles
    repeat (3) @(posedge CK);
    #1;
    chk("rst_grn", int'(GRN), 0);
    chk("rst_ylw", int'(YLW), 0);
    chk("rst_red", int'(RED), 7);
    chk("rst_act", int'(ACT), 0);
    chk("rst_tick", int'(TICK), 0);
    rst_rel();
    exp_q.push_back(seg(3'b000, 3'b000, 3'b111, 2'd0, 4));
    repeat (5) @(posedge CK);
    #1;
    chk("first_grn", int'(GRN), 1);
    chk("first_act", int'(ACT), 0);

    // 2: no demand keeps way 0 green; one tick every 4 cycles
    bad_g  = 0;
    bad_y  = 0;
    n_tick = 0;
    repeat (200) begin
      @(negedge CK);
      if (GRN != 3'b001) bad_g++;
      if (YLW != 3'b000) bad_y++;
      if (TICK) n_tick++;
    end
    chk("idle_grn_changes", bad_g, 0);
    chk("idle_ylw_seen", bad_y, 0);
    chk("idle_ticks", n_tick, 50);

    // 3: pulses on all ways during way-0 green; way 0's own is ignored
    @(posedge CK);
    #2 CLR_N = 1'b0;
    repeat (2) @(posedge CK);
    rst_rel();
    exp_q.push_back(seg(3'b000, 3'b000, 3'b111, 2'd0, 4));
    exp_q.push_back(seg(3'b001, 3'b000, 3'b110, 2'd0, 20));
    exp_q.push_back(seg(3'b000, 3'b001, 3'b110, 2'd0, 8));
    exp_q.push_back(seg(3'b000, 3'b000, 3'b111, 2'd0, 4));
    exp_q.push_back(seg(3'b010, 3'b000, 3'b101, 2'd1, 20));
    exp_q.push_back(seg(3'b000, 3'b010, 3'b101, 2'd1, 8));
    exp_q.push_back(seg(3'b000, 3'b000, 3'b111, 2'd1, 4));
    repeat (5) @(posedge CK);
    #2 REQ = 3'b111;
    @(posedge CK);
    #2 REQ = 3'b000;
    repeat (94) @(posedge CK);
    #1;
    chk("rr_grn", int'(GRN), 4);
    chk("rr_act", int'(ACT), 2);
    chk("rr_ylw", int'(YLW), 0);

    // 4: fast mode at green entry gives a one-tick green
    @(posedge CK);
    #2 CLR_N = 1'b0;
    FM = 1'b1;
    repeat (2) @(posedge CK);
    rst_rel();
    exp_q.push_back(seg(3'b000, 3'b000, 3'b111, 2'd0, 4));
    exp_q.push_back(seg(3'b001, 3'b000, 3'b110, 2'd0, 4));
    exp_q.push_back(seg(3'b000, 3'b001, 3'b110, 2'd0, 8));
    exp_q.push_back(seg(3'b000, 3'b000, 3'b111, 2'd0, 4));
    @(posedge CK);
    #2 REQ = 3'b010;
    @(posedge CK);
    #2 REQ = 3'b000;
    repeat (3) @(posedge CK);
    #2 FM = 1'b0;
    repeat (35) @(posedge CK);
    #1;
    chk("fm_grn", int'(GRN), 2);
    chk("fm_act", int'(ACT), 1);

    // 5: TEST mode; the first tick lands one cycle after release
    @(posedge CK);
    #2 CLR_N = 1'b0;
    TEST = 1'b1;
    repeat (2) @(posedge CK);
    rst_rel();
    REQ = 3'b010;
    exp_q.push_back(seg(3'b000, 3'b000, 3'b111, 2'd0, 2));
    exp_q.push_back(seg(3'b001, 3'b000, 3'b110, 2'd0, 5));
    exp_q.push_back(seg(3'b000, 3'b001, 3'b110, 2'd0, 2));
    exp_q.push_back(seg(3'b000, 3'b000, 3'b111, 2'd0, 1));
    @(posedge CK);
    #2 REQ = 3'b000;
    n_tick = 0;
    repeat (10) begin
      @(negedge CK);
      if (!TICK) n_tick++;
    end
    chk("test_tick_low", n_tick, 0);
    repeat (5) @(posedge CK);
    #1;
    chk("test_grn", int'(GRN), 2);
    chk("test_act", int'(ACT), 1);

    // 6: asynchronous reset in the middle of way-0 yellow
    @(posedge CK);
    #2 CLR_N = 1'b0;
    TEST = 1'b0;
    repeat (2) @(posedge CK);
    rst_rel();
    exp_q.push_back(seg(3'b000, 3'b000, 3'b111, 2'd0, 4));
    exp_q.push_back(seg(3'b001, 3'b000, 3'b110, 2'd0, 20));
    @(posedge CK);
    #2 REQ = 3'b010;
    @(posedge CK);
    #2 REQ = 3'b000;
    repeat (26) @(posedge CK);
    #2;
    chk("pre_rst_ylw", int'(YLW), 1);
    #1 CLR_N = 1'b0;
    #1;
    chk("arst_ylw", int'(YLW), 0);
    chk("arst_red", int'(RED), 7);
    chk("arst_grn", int'(GRN), 0);
    chk("arst_act", int'(ACT), 0);
    repeat (2) @(posedge CK);
    rst_rel();
    exp_q.push_back(seg(3'b000, 3'b000, 3'b111, 2'd0, 4));
    repeat (60) @(posedge CK);
    #1;
    chk("restart_grn", int'(GRN), 1);
    chk("restart_ylw", int'(YLW), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tlc_multiway_ctrl.md
# tlc_multiway_ctrl

Parametrised multi-way traffic-light controller, the next generation of our two-way fixed-sequence light controller. It adds:
- N_WAY approaches served in demand-driven round-robin order;
- per-phase programmable durations with a prescaled time base;
- fast-mode (FM) green shortening and a TEST mode that bypasses the prescaler.

It sits between the intersection request inputs and the lamp drivers; all lamp outputs are registered.

## Interface
Parameters:
- N_WAY, 2, number of approaches (2..8)
- CNT_W, 8, width of phase timer and prescaler
- PRE_DIV, 16, CK cycles per time tick (1..2^CNT_W)
- T_GRN, 40, green duration in ticks (1..2^CNT_W-1)
- T_YLW, 4, yellow duration in ticks (>=1)
- T_ALLRED, 2, all-red clearance in ticks (>=1)
- FM_SHIFT, 2, fast-mode green = max(T_GRN >> FM_SHIFT, 1)

Ports:
- CK  in  1  clock; all state changes on rising edge
- CLR_N  in  1  asynchronous active-low reset
- FM  in  1  fast mode; sampled on green entry
- TEST  in  1  1 = one tick per CK cycle
- REQ  in  N_WAY  per-way demand, level or single-cycle pulse
- GRN  out  N_WAY  green lamps
- YLW  out  N_WAY  yellow lamps
- RED  out  N_WAY  red lamps
- ACT  out  clog2(N_WAY)  index of the way currently owning the right of way
- TICK  out  1  registered time-base tick, for debug

One clock (CK); reset CLR_N is asynchronous and active-low.

## Operation
- **Prescaler:** counts 0..PRE_DIV-1 and asserts TICK for one cycle at terminal count. TEST=1 holds the count at 0 and asserts TICK every cycle. Any TEST edge clears the count.
- **Phase timer:** loaded with duration-1 on state entry, decremented on TICK. The phase ends on the TICK where timer==0, so a phase lasts exactly D ticks.
- **FSM states:** ALLRED, GRN, YLW.
  - ALLRED -> GRN(next) at expiry.
  - GRN -> YLW at expiry, but only if some other way is pending. Otherwise GRN holds, with the timer saturated at 0, and moves to YLW on the first TICK on which another way is pending.
  - YLW -> ALLRED at expiry.
- **Next-way selection:** the first pending way after ACT in circular order (ACT+1, ACT+2, ...). Non-pending ways are skipped.
- **Pending bits:**
  - pending[i] sets on any cycle REQ[i]=1.
  - pending[i] clears on the cycle way i enters GRN. A simultaneous REQ[i] is absorbed (the bit clears).
  - REQ for the way currently green is ignored.
- **Green duration:** T_GRN, or max(T_GRN>>FM_SHIFT,1) if FM=1 at green entry. FM changes mid-green take effect on the next green.
- **Lamp invariants:**
  - For each way, exactly one of GRN/YLW/RED is set.
  - At most one way is non-red.
  - The ACT way shows GRN in GRN, YLW in YLW, and RED in ALLRED.

## Timing
- **Reset values:** GRN=0, YLW=0, RED=all ones, ACT=0, TICK=0, pending=0, prescaler=0. The FSM enters ALLRED with timer=T_ALLRED-1.
- After reset the first green is always way 0, regardless of pending.
- Reset assertion forces outputs immediately, with no clock edge needed. This applies mid-phase, and no partial yellow survives.
- **Latency:**
  - Lamps change on the CK edge following the expiring TICK cycle (one registered stage).
  - REQ to pending takes one cycle. A REQ arriving in the same cycle as the GRN expiry TICK is not counted for that decision.
- **Phase length:** D*PRE_DIV CK cycles, or D cycles when TEST=1.

## Structure
- **Package tlc_pkg:** phase state enum (ALLRED, GRN, YLW); function for fast-mode green length; function for circular next-pending search; elaboration checks on parameter ranges.
- **Sub-module tlc_prescaler** (CK, CLR_N, TEST -> TICK), parametrised by PRE_DIV and CNT_W.
- **Top level** holds the FSM, phase timer, pending register and output registers.

## Test plan
All scenarios use N_WAY=3, PRE_DIV=4, T_GRN=5, T_YLW=2, T_ALLRED=1, FM_SHIFT=2, FM=0, TEST=0 unless stated.

1. **Reset release:** CLR_N low, then released. Required: RED=111 during reset; GRN=001 and ACT=0 after 4 cycles of all-red.
2. **No demand:** REQ=0 for 200 cycles. Required: GRN=001 stays constant and YLW is never set.
3. **Round-robin skip:** one-cycle pulses on REQ[2] and REQ[1] in the same cycle during way-0 green. Required:
   - way 0 green for 20 cycles total, yellow for 8, all-red for 4;
   - then GRN=010, ACT=1, with way 2 still pending;
   - after way 1's sequence, GRN=100.
4. **Fast mode:** FM=1 at green entry with a competing request pending. Required: green lasts 4 cycles (1 tick).
5. **TEST mode:** TEST=1 with a competing request. Required: green 5, yellow 2, all-red 1 cycles; TICK high every cycle.
6. **Reset mid-operation:** CLR_N asserted mid-yellow, between clock edges. Required: immediately YLW=000 and RED=111; after release, pending=0 and the sequence restarts as in scenario 1.
